// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory-map port shared by mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory-management side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              m0_req, m0_we, m0_ack, m0_err;
  logic [ADDR_W-1:0] m0_addr, m0_wdata;
  logic              m1_req, m1_we, m1_ack, m1_err;
  logic [ADDR_W-1:0] m1_addr, m1_wdata;
  logic [ADDR_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              mem_we;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_err, m1_ack, m1_err,
    output rdata, mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_err, m1_ack, m1_err,
    input  rdata, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared memory-map port. Each access runs
// IDLE -> GRANT -> ACCESS -> DONE; writes outside [RAM_BASE, RAM_LIMIT) are dropped and flagged.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAM_BASE  = 'h100,
  parameter int unsigned RAM_LIMIT = 'h200
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_e;

  localparam logic [ADDR_W-1:0] RAM_LO = ADDR_W'(RAM_BASE);
  localparam logic [ADDR_W-1:0] RAM_HI = ADDR_W'(RAM_LIMIT);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;          // 0 = M0, 1 = M1
  logic              last_owner_q, last_owner_d;
  logic              blocked_q, blocked_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]        req;
  logic              own_we, in_win;
  logic [ADDR_W-1:0] own_addr, own_wdata;

  // Payload is never latched; the owner must hold it stable until its ack.
  assign req       = {bus.m1_req, bus.m0_req};
  assign own_we    = owner_q ? bus.m1_we    : bus.m0_we;
  assign own_addr  = owner_q ? bus.m1_addr  : bus.m0_addr;
  assign own_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;
  assign in_win    = (own_addr >= RAM_LO) && (own_addr < RAM_HI);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    blocked_d    = blocked_q;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    bus.mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          owner_d = (req == 2'b11) ? ~last_owner_q : req[1];
          state_d = GRANT;
        end
      end
      GRANT: begin
        mem_addr_d  = own_addr;
        mem_wdata_d = own_wdata;
        state_d     = ACCESS;
      end
      ACCESS: begin
        mem_addr_d   = own_addr;
        mem_wdata_d  = own_wdata;
        bus.mem_we   = own_we & in_win;
        blocked_d    = own_we & ~in_win;
        if (!own_we) rdata_d = bus.mem_rdata;
        last_owner_d = owner_q;
        state_d      = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_addr/mem_wdata follow the owner while granted and hold the last value otherwise.
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q == GRANT) || (state_q == ACCESS);
  assign bus.m0_ack    = (state_q == DONE) && !owner_q;
  assign bus.m1_ack    = (state_q == DONE) &&  owner_q;
  assign bus.m0_err    = bus.m0_ack && blocked_q;
  assign bus.m1_err    = bus.m1_ack && blocked_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      blocked_q    <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      blocked_q    <= blocked_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory-map port (ROM 0x000-0x0FF, RAM 0x100-0x1FF, switch registers 0x204-0x21C) between two requesters: the CPU data port (M0) and the character-buffer loader/DMA (M1).
- Sequences each access as a fixed three-state transaction and arbitrates round-robin between M0 and M1.
- Registers the read data and returns it to the requester.
- Blocks writes outside the RAM window and flags them as errors.

Parameters:
- ADDR_W, 32, address and data width of both requesters and of the memory port.
- RAM_BASE, 'h100, first writable address.
- RAM_LIMIT, 'h200, first address above the writable window (exclusive).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  M0 access request; held high until m0_ack.
- m0_we  in  1  M0 write enable; 1 = write, 0 = read.
- m0_addr  in  ADDR_W  M0 byte address.
- m0_wdata  in  ADDR_W  M0 write data.
- m0_ack  out  1  one-cycle completion pulse to M0.
- m0_err  out  1  valid with m0_ack; the write was blocked.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err: same as the M0 signals, for M1.
- rdata  out  ADDR_W  registered read data; valid in the ack cycle of the owner.
- mem_addr  out  ADDR_W  address to the memory-management block.
- mem_wdata  out  ADDR_W  write data to the memory-management block.
- mem_we  out  1  write strobe to the memory-management block (wboolean).
- mem_rdata  in  ADDR_W  combinational read data from the memory-management block.
- busy  out  1  high while in the GRANT or ACCESS state.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE and owner to M0.
  - last_owner goes to M1, so M0 wins the first tie.
  - rdata = 0; all acks, errs, mem_we and busy = 0; mem_addr and mem_wdata = 0.
- The FSM has four states: IDLE, GRANT, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One requester active: select it as owner and go to GRANT.
  - Both active: select the requester that is not last_owner, then go to GRANT.
- GRANT:
  - Drive mem_addr and mem_wdata from the owner's inputs; mem_we = 0.
  - This cycle is the address setup cycle. Go to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata still come from the owner.
  - mem_we = owner_we AND (RAM_BASE <= addr < RAM_LIMIT).
  - Latch blocked = owner_we AND NOT in-window.
  - On the edge leaving ACCESS, capture rdata <= mem_rdata for reads only; on writes rdata holds its value.
  - Update last_owner <= owner. Go to DONE.
- DONE:
  - Assert the owner's ack for exactly one cycle, and its err = blocked.
  - mem_we = 0 and mem_addr holds its value. Go to IDLE.
- Latency and throughput:
  - Request sampled in IDLE at edge N; ack is high in cycle N+3.
  - Minimum spacing between two transactions is 4 cycles, because IDLE is always visited.
- Request-signal rules:
  - A requester must hold req, we, addr and wdata stable from assertion until its ack.
  - The block latches only the owner ID, never the request payload.
  - If the owner drops req during GRANT or ACCESS, the transaction still completes and ack is still pulsed.
  - A non-owner's req is ignored until IDLE.
- A requester that keeps req high after its ack is treated as a new request in IDLE.
- Round-robin guarantees the other requester is served next on any tie, so neither requester can be starved.
- A read at any address (ROM, RAM, switches, unmapped) is never an error; unmapped reads return whatever mem_rdata gives (0).
- Address boundaries:
  - A write to RAM_LIMIT-1 ('h1FF) is allowed.
  - Writes to 'h0FF, 'h200 or 'h204 are blocked: no mem_we pulse, err = 1.
- Reset asserted mid-transaction:
  - Immediately forces mem_we = 0 and both acks to 0.
  - No ack is issued for the aborted access; the requester must re-request.

Test Plan:
- Read from ROM: M0 read at addr 'h010 with mem_rdata='hA5. Required: m0_ack high exactly 3 cycles after the request is sampled, rdata='hA5, m0_err=0, mem_we never high.
- Write to RAM: M1 write at addr 'h120 with data 'h3C. Required: mem_we high for exactly one cycle (ACCESS) with mem_addr='h120 and mem_wdata='h3C; m1_ack follows one cycle later with m1_err=0.
- Simultaneous requests after reset: M0 and M1 both request. Required order M0, M1, M0, M1 across four transactions; each ack is a single pulse; acks are 4 cycles apart.
- Blocked writes: writes to 'h0FF, 'h200 and 'h210. Required for each: mem_we stays 0, err=1 in the ack cycle, rdata unchanged. A write to 'h1FF gives mem_we=1 and err=0.
- Reset during ACCESS: assert rst while the state is ACCESS on a write. Required: mem_we falls immediately, no ack is issued, and state is IDLE after rst deasserts. The re-request then completes normally.
- Owner drops req: M0 drops req during GRANT. Required: m0_ack is still pulsed in DONE, after which the block returns to IDLE and serves the pending M1.
